debounced_inputs: RTL and testbench

DEBOUNCED_INPUTS -- requirements
Module: debounced_inputs

---
 rtl/simple_fpga_cvs_pkg.sv | 14 +
 rtl/debounce_channel.sv | 71 +++++++
 rtl/debounced_inputs.sv | 61 ++++++
 tb/tb_debounced_inputs.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_fpga_cvs_pkg.sv
// rtl/simple_fpga_cvs_pkg.sv - shared defaults and helpers for the debounced input block
package simple_fpga_cvs_pkg;

   localparam int unsigned DEF_CHANNELS     = 5;
   localparam int unsigned DEF_CLK_HZ       = 300_000_000;
   localparam int unsigned DEF_TICK_HZ      = 1000;
   localparam int unsigned DEF_STABLE_TICKS = 8;

   // Clock cycles per debounce sample tick.
   function automatic int unsigned prescale_div(input int unsigned clk_hz, input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced input: synchronizer, stability counter, edge pulses, toggle
module debounce_channel
   import simple_fpga_cvs_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic in_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic toggle_o
);

   localparam int unsigned   CW       = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          meta_q;
   logic          sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          db_q;
   logic          db_d;
   logic          rise_q;
   logic          fall_q;
   logic          tog_q;

   // Any sample that agrees with the accepted level throws away progress.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_q == db_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = sync_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         tog_q  <= 1'b0;
      end else begin
         meta_q <= in_i;
         sync_q <= meta_q;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= db_d & ~db_q;
         fall_q <= ~db_d & db_q;
         tog_q  <= tog_q ^ (db_d & ~db_q);
      end
   end

   assign db_o     = db_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign toggle_o = tog_q;

endmodule

// File: rtl/debounced_inputs.sv
// rtl/debounced_inputs.sv - bank of debounced switch inputs sharing one sample-tick prescaler
module debounced_inputs
   import simple_fpga_cvs_pkg::*;
#(
   parameter int unsigned CHANNELS     = DEF_CHANNELS,
   parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
   parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] in_db,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] toggle_q,
   output logic                any_change
);

   localparam int unsigned DIV = prescale_div(CLK_HZ, TICK_HZ);
   localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2 || STABLE_TICKS < 1 || CHANNELS < 1 || CHANNELS > 32) begin : g_bad_params
         $error("debounced_inputs: need CLK_HZ/TICK_HZ >= 2, STABLE_TICKS >= 1, CHANNELS in 1..32");
      end
   endgenerate

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic          tick;

   assign tick  = (pre_q == PW'(DIV - 1));
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick_i  (tick),
         .in_i    (in[g]),
         .db_o    (in_db[g]),
         .rise_o  (rise[g]),
         .fall_o  (fall[g]),
         .toggle_o(toggle_q[g])
      );
   end

   assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounced_inputs.sv
// tb/tb_debounced_inputs.sv - self-checking bench for debounced_inputs with a tick-counting reference model
module tb_debounced_inputs;

   localparam int CH  = 5;
   localparam int DIV = 10;
   localparam int ST  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] in_r = '0;
   logic [CH-1:0] in_db;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] toggle_q;
   logic          any_change;

   always #5 clk = ~clk;

   debounced_inputs #(
      .CHANNELS(CH), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(ST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in(in_r), .in_db(in_db), .rise(rise),
      .fall(fall), .toggle_q(toggle_q), .any_change(any_change)
   );

   int checks = 0;
   int errors = 0;

   int            n;
   logic [CH-1:0] in_hist[$];
   logic [CH-1:0] m_db, m_rise, m_fall, m_tog;
   int            since[CH];
   int            rise_cnt[CH], fall_cnt[CH], rise_cyc[CH], fall_cyc[CH];
   int            any_cnt;
   logic [CH-1:0] cur;
   int            hold[CH];
   int            c0, lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      in_hist.delete();
      m_db = '0; m_rise = '0; m_fall = '0; m_tog = '0;
      for (int i = 0; i < CH; i++) since[i] = -1;
   endtask

   task automatic clr_obs();
      any_cnt = 0;
      for (int i = 0; i < CH; i++) begin
         rise_cnt[i] = 0; fall_cnt[i] = 0; rise_cyc[i] = -1; fall_cyc[i] = -1;
      end
   endtask

   // Called #1 after an edge: compare cycle n, drive input for cycle n, predict cycle n+1.
   task automatic cyc(input logic [CH-1:0] v);
      logic [CH-1:0] s, nxt;
      int            ticks;
      chk($sformatf("cycle%0d", n), 32'({in_db, rise, fall, toggle_q, any_change}),
          32'({m_db, m_rise, m_fall, m_tog, |(m_rise | m_fall)}));
      for (int i = 0; i < CH; i++) begin
         if (rise[i]) begin rise_cnt[i]++; rise_cyc[i] = n; end
         if (fall[i]) begin fall_cnt[i]++; fall_cyc[i] = n; end
      end
      if (any_change) any_cnt++;
      in_r = v;
      in_hist.push_back(v);
      s   = (n >= 2) ? in_hist[n-2] : '0;
      nxt = m_db;
      for (int i = 0; i < CH; i++) begin
         if (s[i] != m_db[i]) begin
            if (since[i] < 0) since[i] = n;
            // ticks fall on cycles t with t mod DIV == DIV-1, counted over [since, n]
            ticks = (n + 1) / DIV - since[i] / DIV;
            if (ticks >= ST) begin
               nxt[i]   = s[i];
               since[i] = -1;
            end
         end else begin
            since[i] = -1;
         end
      end
      m_rise = nxt & ~m_db;
      m_fall = ~nxt & m_db;
      m_tog  = m_tog ^ m_rise;
      m_db   = nxt;
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic run(input logic [CH-1:0] v, input int k);
      for (int j = 0; j < k; j++) cyc(v);
   endtask

   task automatic do_reset(input int hold_cycles);
      rst_n = 1'b0;
      #1;
      chk("async_reset", 32'({in_db, rise, fall, toggle_q, any_change}), 32'd0);
      for (int j = 0; j < hold_cycles; j++) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      cur = '0;
      model_reset();
      clr_obs();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 32'({in_db, rise, fall, toggle_q, any_change}), 32'd0);
      rst_n = 1'b1;

      // idle: nothing may move
      run(cur, 200);
      chk("idle_any_change", 32'(any_cnt), 32'd0);
      chk("idle_in_db", 32'(in_db), 32'd0);

      // clean press on channel 0
      clr_obs();
      cur[0] = 1'b1;
      c0 = n;
      run(cur, 60);
      lat = rise_cyc[0] - c0;
      chk("ch0_rise_count", 32'(rise_cnt[0]), 32'd1);
      chk("ch0_latency_window", 32'(lat >= 33 && lat <= 42), 32'd1);
      chk("ch0_in_db", 32'(in_db[0]), 32'd1);
      chk("ch0_toggle", 32'(toggle_q[0]), 32'd1);
      chk("ch0_any_change_count", 32'(any_cnt), 32'd1);

      // bouncing channel 1, 7-cycle segments, then held high
      clr_obs();
      for (int seg = 0; seg < 10; seg++) begin
         cur[1] = (seg % 2 == 0);
         run(cur, 7);
      end
      cur[1] = 1'b1;
      c0 = n;
      run(cur, 60);
      lat = rise_cyc[1] - c0;
      chk("ch1_rise_count", 32'(rise_cnt[1]), 32'd1);
      chk("ch1_fall_count", 32'(fall_cnt[1]), 32'd0);
      chk("ch1_latency_window", 32'(lat >= 33 && lat <= 42), 32'd1);

      // short glitch on channel 3
      clr_obs();
      cur[3] = 1'b1;
      run(cur, 25);
      cur[3] = 1'b0;
      run(cur, 60);
      chk("ch3_glitch_edges", 32'(rise_cnt[3] + fall_cnt[3]), 32'd0);
      chk("ch3_glitch_state", 32'({in_db[3], toggle_q[3]}), 32'd0);

      // two press/release cycles on channel 2
      clr_obs();
      cur[2] = 1'b1; run(cur, 60);
      chk("ch2_toggle_press1", 32'(toggle_q[2]), 32'd1);
      cur[2] = 1'b0; run(cur, 60);
      chk("ch2_toggle_release1", 32'(toggle_q[2]), 32'd1);
      cur[2] = 1'b1; run(cur, 60);
      chk("ch2_toggle_press2", 32'(toggle_q[2]), 32'd0);
      cur[2] = 1'b0; run(cur, 60);
      chk("ch2_toggle_release2", 32'(toggle_q[2]), 32'd0);
      chk("ch2_rise_fall_counts", 32'({rise_cnt[2][7:0], fall_cnt[2][7:0]}), 32'h0202);

      // simultaneous press on channels 0 and 4
      cur[0] = 1'b0; run(cur, 60);
      clr_obs();
      cur[0] = 1'b1; cur[4] = 1'b1;
      run(cur, 60);
      chk("ch0_ch4_rise_counts", 32'({rise_cnt[0][7:0], rise_cnt[4][7:0]}), 32'h0101);
      chk("ch0_ch4_same_cycle", 32'(rise_cyc[0] == rise_cyc[4] && rise_cyc[0] >= 0), 32'd1);

      // reset in the middle of an acceptance on channel 3
      clr_obs();
      cur[3] = 1'b1;
      run(cur, 20);
      do_reset(3);
      clr_obs();
      run(cur, 60);
      chk("ch3_after_reset_rise_count", 32'(rise_cnt[3]), 32'd1);
      chk("ch3_after_reset_window", 32'(rise_cyc[3] >= 33 && rise_cyc[3] <= 42), 32'd1);
      chk("held_inputs_after_reset", 32'(in_db), 32'(cur));

      // random hold lengths around the acceptance threshold
      for (int i = 0; i < CH; i++) hold[i] = 0;
      for (int k = 0; k < 1500; k++) begin
         if (k == 700) do_reset($urandom_range(1, 5));
         for (int i = 0; i < CH; i++) begin
            if (hold[i] == 0) begin
               cur[i]  = 1'($urandom_range(0, 1));
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 45) : $urandom_range(1, 12);
            end
            hold[i]--;
         end
         cyc(cur);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
